// File: rtl/antic_line_buffer.sv
// Playfield line buffer and pixel shifter for the ANTIC DMA path.
// Captures one mode line of screen bytes once, then replays them as AN pixel codes per scanline.
module antic_line_buffer #(
   parameter int unsigned MAX_BYTES = 48,
   parameter int unsigned PTR_W     = 6
) (
   input  logic             Fphi0,
   input  logic             RST,
   input  logic             line_start,
   input  logic [PTR_W-1:0] bytes_cfg,
   input  logic             bpp2,
   input  logic [3:0]       scan_lines,
   output logic             dma_req,
   input  logic             dma_valid,
   input  logic [7:0]       dma_data,
   input  logic             scan_start,
   input  logic             pix_en,
   output logic [2:0]       AN,
   output logic             pix_valid,
   output logic             busy,
   output logic             line_done
);

   localparam logic [PTR_W-1:0] MAX_P = PTR_W'(MAX_BYTES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WAIT  = 2'd2,
      SHIFT = 2'd3
   } state_t;

   state_t           state;
   logic [PTR_W-1:0] nbytes;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             bpp2_q;
   logic [3:0]       lines_q;
   logic [3:0]       sl_cnt;
   logic [2:0]       pix_idx;

   logic [7:0]       line_mem [MAX_BYTES];

   logic [PTR_W-1:0] cfg_clamped;
   logic [PTR_W-1:0] last_ptr;
   logic             wr_en;
   logic [7:0]       cur_byte;
   logic [2:0]       shamt;
   logic [7:0]       shifted;
   logic [1:0]       pair;
   logic [2:0]       pix_code;
   logic             byte_end;

   // Zero or oversize byte counts select the full wide playfield.
   assign cfg_clamped = (bytes_cfg == '0 || bytes_cfg > MAX_P) ? MAX_P : bytes_cfg;
   assign last_ptr    = nbytes - PTR_W'(1);

   // A DMA byte is accepted only while the buffer is asking for one.
   assign wr_en = !RST && !line_start && (state == FILL) && dma_req && dma_valid;

   always_ff @(posedge Fphi0) begin
      if (wr_en) begin
         line_mem[wr_ptr] <= dma_data;
      end
   end

   // Pixel extraction: shift the current pixel to the top of the byte, MSB first.
   assign cur_byte = line_mem[rd_ptr];
   assign shamt    = bpp2_q ? {pix_idx[1:0], 1'b0} : pix_idx;
   assign shifted  = cur_byte << shamt;
   assign pair     = shifted[7:6];
   assign pix_code = bpp2_q ? ((pair == 2'b00) ? 3'b000 : {1'b1, pair - 2'b01})
                            : {shifted[7], 2'b00};
   assign byte_end = bpp2_q ? (pix_idx[1:0] == 2'd3) : (pix_idx == 3'd7);

   // Sequencer: fill once per mode line, replay per scanline.
   always_ff @(posedge Fphi0) begin
      if (RST) begin
         state     <= IDLE;
         nbytes    <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         bpp2_q    <= 1'b0;
         lines_q   <= '0;
         sl_cnt    <= '0;
         pix_idx   <= '0;
         dma_req   <= 1'b0;
         AN        <= 3'b000;
         pix_valid <= 1'b0;
         busy      <= 1'b0;
         line_done <= 1'b0;
      end else begin
         pix_valid <= 1'b0;
         AN        <= 3'b000;
         line_done <= 1'b0;
         if (line_start) begin
            state   <= FILL;
            nbytes  <= cfg_clamped;
            bpp2_q  <= bpp2;
            lines_q <= scan_lines;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pix_idx <= '0;
            sl_cnt  <= '0;
            dma_req <= 1'b1;
            busy    <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  dma_req <= 1'b0;
                  busy    <= 1'b0;
               end
               FILL: begin
                  if (dma_valid && dma_req) begin
                     if (wr_ptr == last_ptr) begin
                        state   <= WAIT;
                        dma_req <= 1'b0;
                     end else begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                     end
                  end
               end
               WAIT: begin
                  if (scan_start) begin
                     state   <= SHIFT;
                     rd_ptr  <= '0;
                     pix_idx <= '0;
                  end
               end
               SHIFT: begin
                  if (pix_en) begin
                     pix_valid <= 1'b1;
                     AN        <= pix_code;
                     if (byte_end) begin
                        pix_idx <= '0;
                        if (rd_ptr == last_ptr) begin
                           if (sl_cnt == lines_q) begin
                              line_done <= 1'b1;
                              state     <= IDLE;
                              busy      <= 1'b0;
                           end else begin
                              sl_cnt <= sl_cnt + 4'd1;
                              state  <= WAIT;
                           end
                        end else begin
                           rd_ptr <= rd_ptr + PTR_W'(1);
                        end
                     end else begin
                        pix_idx <= pix_idx + 3'd1;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_antic_line_buffer.sv
// Scoreboard bench for antic_line_buffer: stimulus pushes expected pixels, a negedge monitor pops them.
module tb_antic_line_buffer;

   localparam int MAXB  = 48;
   localparam int PTR_W = 6;

   logic             Fphi0 = 1'b0;
   logic             RST = 1'b1;
   logic             line_start = 1'b0;
   logic [PTR_W-1:0] bytes_cfg = '0;
   logic             bpp2 = 1'b0;
   logic [3:0]       scan_lines = '0;
   logic             dma_valid = 1'b0;
   logic [7:0]       dma_data = '0;
   logic             scan_start = 1'b0;
   logic             pix_en = 1'b0;
   logic             dma_req;
   logic [2:0]       AN;
   logic             pix_valid;
   logic             busy;
   logic             line_done;

   antic_line_buffer #(.MAX_BYTES(48), .PTR_W(6)) dut (
      .Fphi0      (Fphi0),
      .RST        (RST),
      .line_start (line_start),
      .bytes_cfg  (bytes_cfg),
      .bpp2       (bpp2),
      .scan_lines (scan_lines),
      .dma_req    (dma_req),
      .dma_valid  (dma_valid),
      .dma_data   (dma_data),
      .scan_start (scan_start),
      .pix_en     (pix_en),
      .AN         (AN),
      .pix_valid  (pix_valid),
      .busy       (busy),
      .line_done  (line_done)
   );

   always #5 Fphi0 = ~Fphi0;

   typedef struct packed {
      logic [2:0] an;
      logic       done;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   int           tests = 0;
   int           fails = 0;
   bit           mon_en = 1'b0;
   byte unsigned model_mem[MAXB];
   byte unsigned stim[64];
   int           m_nb = 0;
   int           m_ppb = 8;
   bit           m_bpp2 = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp_n(input int cfg);
      return (cfg == 0 || cfg > MAXB) ? MAXB : cfg;
   endfunction

   // Reference pixel code: pixel i of byte b, MSB first.
   function automatic int pixel_code(input byte unsigned b, input bit two, input int i);
      int v;
      if (two) begin
         v = (int'(b) >> (6 - 2 * i)) & 3;
         return (v == 0) ? 0 : v + 3;
      end
      v = (int'(b) >> (7 - i)) & 1;
      return v * 4;
   endfunction

   task automatic tick();
      @(posedge Fphi0);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_AN"}, AN, 0);
      chk({tag, "_dma_req"}, dma_req, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_line_done"}, line_done, 0);
      chk({tag, "_pix_valid"}, pix_valid, 0);
   endtask

   task automatic start_line(input int cfg, input bit two, input int sl, input bit with_pix);
      line_start = 1'b1;
      bytes_cfg  = PTR_W'(cfg);
      bpp2       = two;
      scan_lines = 4'(sl);
      pix_en     = with_pix;
      tick();
      line_start = 1'b0;
      pix_en     = 1'b0;
      m_nb   = clamp_n(cfg);
      m_bpp2 = two;
      m_ppb  = two ? 4 : 8;
      chk("dma_req_after_start", dma_req, 1);
      chk("busy_after_start", busy, 1);
   endtask

   task automatic fill(input int pulses, input int min_gap, input int max_gap, input bit ss_in_gap);
      for (int p = 0; p < pulses; p++) begin
         int gap;
         gap = int'($urandom_range(max_gap, min_gap));
         for (int g = 0; g < gap; g++) begin
            dma_valid  = 1'b0;
            scan_start = ss_in_gap && (p < m_nb);
            chk("dma_req_stall", dma_req, int'(p < m_nb));
            tick();
         end
         scan_start = 1'b0;
         chk("dma_req_pulse", dma_req, int'(p < m_nb));
         dma_valid = 1'b1;
         dma_data  = stim[p];
         if (p < m_nb) model_mem[p] = stim[p];
         tick();
      end
      dma_valid = 1'b0;
      chk("dma_req_filled", dma_req, 0);
      chk("busy_filled", busy, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 8) begin
         tick();
         n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
      sb.delete();
   endtask

   task automatic scanline(input bit last, input int gap_pct, input bit ss_mid, input bit dv_mid,
                           input int stop_at);
      int npix;
      int lim;
      int k;
      npix = m_nb * m_ppb;
      lim  = (stop_at >= 0) ? stop_at : npix;
      k    = 0;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      while (k < lim) begin
         bit   pe;
         exp_t e;
         pe         = ($urandom_range(99, 0) >= 32'(gap_pct));
         pix_en     = pe;
         scan_start = ss_mid && (k == npix / 2);
         dma_valid  = dv_mid && (k == 1);
         dma_data   = 8'($urandom);
         if (pe) begin
            e.an   = 3'(pixel_code(model_mem[k / m_ppb], m_bpp2, k % m_ppb));
            e.done = last && (k == npix - 1);
            sb.push_back(e);
            k++;
         end
         tick();
      end
      pix_en     = 1'b0;
      scan_start = 1'b0;
      dma_valid  = 1'b0;
      if (stop_at < 0) begin
         drain();
         chk("busy_after_scanline", busy, int'(!last));
      end
   endtask

   // Monitor: every pixel must match the head of the scoreboard; idle cycles must be quiet.
   initial begin
      forever begin
         @(negedge Fphi0);
         if (mon_en) begin
            if (pix_valid) begin
               if (sb.size() == 0) begin
                  chk("unexpected_pixel", 1, 0);
               end else begin
                  mon_e = sb.pop_front();
                  chk("AN", AN, mon_e.an);
                  chk("line_done", line_done, mon_e.done);
               end
            end else begin
               chk("AN_idle", AN, 0);
               chk("line_done_idle", line_done, 0);
            end
         end
      end
   end

   initial begin
      #400000;
      fails++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with noisy inputs.
      RST = 1'b1; dma_valid = 1'b1; pix_en = 1'b1; dma_data = 8'h5A;
      repeat (3) tick();
      chk_idle_outputs("reset");
      RST = 1'b0; dma_valid = 1'b0; pix_en = 1'b0;
      mon_en = 1'b1;
      tick();

      // 2bpp fill/replay, two scanlines.
      stim[0] = 8'h1B; stim[1] = 8'hE4;
      start_line(2, 1'b1, 1, 1'b0);
      fill(2, 0, 0, 1'b0);
      scanline(1'b0, 0, 1'b0, 1'b0, -1);
      scanline(1'b1, 0, 1'b0, 1'b0, -1);

      // 1bpp with DMA stalls.
      stim[0] = 8'hA5;
      start_line(1, 1'b0, 0, 1'b0);
      fill(1, 2, 4, 1'b0);
      scanline(1'b1, 0, 1'b0, 1'b0, -1);

      // Clamp to 48 bytes, two extra DMA pulses ignored.
      for (int i = 0; i < 50; i++) stim[i] = 8'($urandom);
      start_line(0, 1'b1, 0, 1'b0);
      fill(50, 0, 1, 1'b0);
      scanline(1'b1, 20, 1'b0, 1'b0, -1);

      // Abort mid-SHIFT with a new one-byte line.
      for (int i = 0; i < 3; i++) stim[i] = 8'($urandom);
      start_line(3, 1'b1, 2, 1'b0);
      fill(3, 0, 1, 1'b0);
      scanline(1'b0, 0, 1'b0, 1'b0, -1);
      scanline(1'b0, 30, 1'b0, 1'b0, 5);
      stim[0] = 8'($urandom);
      start_line(1, 1'b1, 0, 1'b0);
      fill(1, 0, 0, 1'b0);
      scanline(1'b1, 0, 1'b0, 1'b0, -1);

      // line_start coincident with the final pixel: no pixel, no line_done.
      stim[0] = 8'($urandom);
      start_line(1, 1'b0, 0, 1'b0);
      fill(1, 0, 0, 1'b0);
      scanline(1'b1, 0, 1'b0, 1'b0, 7);
      for (int i = 0; i < 2; i++) stim[i] = 8'($urandom);
      start_line(2, 1'b1, 0, 1'b1);
      fill(2, 0, 0, 1'b0);
      scanline(1'b1, 0, 1'b0, 1'b0, -1);

      // Ignored pulses: scan_start in FILL/SHIFT, pix_en in WAIT, dma_valid in SHIFT.
      for (int i = 0; i < 2; i++) stim[i] = 8'($urandom);
      start_line(2, 1'b0, 1, 1'b0);
      fill(2, 1, 2, 1'b1);
      pix_en = 1'b1;
      repeat (3) tick();
      pix_en = 1'b0;
      chk("busy_wait_pix_en", busy, 1);
      scanline(1'b0, 10, 1'b1, 1'b1, -1);
      scanline(1'b1, 10, 1'b1, 1'b0, -1);
      scan_start = 1'b1; pix_en = 1'b1;
      tick();
      scan_start = 1'b0; pix_en = 1'b0;
      tick();
      chk("idle_scan_start_ignored", busy, 0);

      // Reset during FILL overrides a simultaneous line_start and DMA write.
      stim[0] = 8'($urandom); stim[1] = 8'($urandom);
      start_line(4, 1'b1, 0, 1'b0);
      RST = 1'b1; line_start = 1'b1; dma_valid = 1'b1; pix_en = 1'b1;
      tick();
      chk_idle_outputs("mid_reset");
      RST = 1'b0; line_start = 1'b0; dma_valid = 1'b0; pix_en = 1'b0;
      tick();
      chk("post_reset_busy", busy, 0);

      // Randomised mode lines.
      for (int t = 0; t < 8; t++) begin
         int cfg;
         int sl;
         bit two;
         cfg = ($urandom_range(7, 0) == 0) ? int'($urandom_range(63, 49)) : int'($urandom_range(8, 1));
         two = 1'($urandom);
         sl  = int'($urandom_range(2, 0));
         for (int i = 0; i < 64; i++) stim[i] = 8'($urandom);
         start_line(cfg, two, sl, 1'b0);
         fill(clamp_n(cfg), 0, 2, 1'($urandom));
         for (int s = 0; s <= sl; s++) begin
            scanline(s == sl, 25, 1'($urandom), (s < sl) && 1'($urandom), -1);
         end
      end

      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
